// File: rtl/alu_issue.sv
// alu_issue: single-command issue stage in front of a combinational ALU.
// Owns the register file, drives registered ALU inputs and returns each result over valid/ready.
module alu_issue #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 8,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_load,
  input  logic [2:0]            cmd_oc,
  input  logic [AW-1:0]         cmd_dst,
  input  logic [AW-1:0]         cmd_src_a,
  input  logic [AW-1:0]         cmd_src_b,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [AW-1:0]         res_dst,
  output logic                  res_div0
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] OC_DIV = 3'd3;

  logic [1:0]            state_r;
  logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
  logic [DATA_WIDTH-1:0] result_s;
  logic                  div0_s;

  // Divide-by-zero overrides whatever the ALU produces with all ones
  always_comb begin
    result_s = alu_f;
    div0_s   = 1'b0;
    if ((alu_oc == OC_DIV) && (alu_b == {DATA_WIDTH{1'b0}})) begin
      result_s = {DATA_WIDTH{1'b1}};
      div0_s   = 1'b1;
    end else begin
      result_s = alu_f;
      div0_s   = 1'b0;
    end
  end

  // Command FSM, register file, ALU input and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cmd_ready <= 1'b1;
      alu_oc    <= 3'd0;
      alu_a     <= {DATA_WIDTH{1'b0}};
      alu_b     <= {DATA_WIDTH{1'b0}};
      res_valid <= 1'b0;
      res_data  <= {DATA_WIDTH{1'b0}};
      res_dst   <= {AW{1'b0}};
      res_div0  <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            res_dst   <= cmd_dst;
            if (cmd_load) begin
              regs_r[cmd_dst] <= cmd_imm;
              res_data        <= cmd_imm;
              res_div0        <= 1'b0;
              res_valid       <= 1'b1;
              state_r         <= RESP;
            end else begin
              // Operands sampled before any write-back at this edge
              alu_oc  <= cmd_oc;
              alu_a   <= regs_r[cmd_src_a];
              alu_b   <= regs_r[cmd_src_b];
              state_r <= EXEC;
            end
          end
        end
        EXEC: begin
          regs_r[res_dst] <= result_s;
          res_data        <= result_s;
          res_div0        <= div0_s;
          res_valid       <= 1'b1;
          state_r         <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
